// File: rtl/vga_text_fetch_pkg.sv
// Shared constants for the text-mode fetch path: window geometry, fetch phases
// and the character-code field layout.
package vga_text_fetch_pkg;

  localparam int unsigned X_START_DEF   = 64;
  localparam int unsigned Y_START_DEF   = 48;

  localparam int unsigned COLS          = 32;
  localparam int unsigned ROWS          = 16;
  localparam int unsigned LINES_PER_ROW = 12;
  localparam int unsigned CELL_W        = 16;  // 8 source pixels, doubled
  localparam int unsigned CELL_H        = 24;  // 12 source lines, doubled
  localparam int unsigned WIN_W         = COLS * CELL_W;
  localparam int unsigned WIN_H         = ROWS * CELL_H;
  localparam int unsigned FETCH_LEAD    = CELL_W;

  // Code byte fields
  localparam int unsigned CODE_SG4_BIT  = 7;
  localparam int unsigned CODE_INV_BIT  = 6;
  localparam int unsigned GLYPH_MSB     = 5;
  localparam int unsigned GLYPH_LSB     = 0;

  // Semigraphics-4 cells switch from the upper to the lower quadrant pair here
  localparam logic [3:0] SG4_SPLIT_LINE = 4'd6;

  // Phase of the 16-clock cell fetch slot at which each step happens
  localparam logic [3:0] PH_ADDR  = 4'd0;
  localparam logic [3:0] PH_CODE  = 4'd2;
  localparam logic [3:0] PH_PAT   = 4'd3;
  localparam logic [3:0] PH_SHIFT = 4'd15;

endpackage

// File: rtl/vga_text_pattern.sv
// Turns a character code plus ROM row byte into the 8-pixel pattern for a cell:
// plain glyph, inverse glyph, or semigraphics-4 blocks.
module vga_text_pattern
  import vga_text_fetch_pkg::*;
(
  input  logic       sg4,
  input  logic       inv,
  input  logic [3:0] quad,
  input  logic [3:0] line,
  input  logic [7:0] cg_data,
  output logic [7:0] pattern
);

  logic upper;
  logic left_on;
  logic right_on;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pattern  = cg_data;
    upper    = (line < SG4_SPLIT_LINE);
    left_on  = upper ? quad[3] : quad[1];
    right_on = upper ? quad[2] : quad[0];
    if (sg4) begin
      pattern = {{4{left_on}}, {4{right_on}}};
    end else if (inv) begin
      pattern = ~cg_data;
    end
  end

endmodule

// File: rtl/vga_text_fetch.sv
// Text-window fetch and serialiser: reads codes from video RAM one cell ahead,
// addresses the character ROM and shifts the 8x12 cells out doubled in x and y.
module vga_text_fetch
  import vga_text_fetch_pkg::*;
#(
  parameter int unsigned X_START = X_START_DEF,
  parameter int unsigned Y_START = Y_START_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [8:0] vram_addr,
  input  logic [7:0] vram_data,
  output logic [9:0] cg_addr,
  input  logic [7:0] cg_data,
  output logic       pixel,
  output logic       pixel_en
);

  localparam logic [9:0] X_WIN_LO   = 10'(X_START);
  localparam logic [9:0] X_WIN_HI   = 10'(X_START + WIN_W);
  localparam logic [9:0] X_FETCH_LO = 10'(X_START - FETCH_LEAD);
  localparam logic [9:0] X_FETCH_HI = 10'(X_START + WIN_W - FETCH_LEAD);
  localparam logic [9:0] Y_WIN_LO   = 10'(Y_START);
  localparam logic [9:0] Y_WIN_HI   = 10'(Y_START + WIN_H);

  logic [7:0] code_r;
  logic [7:0] next_pat;
  logic [7:0] cur_pat;
  logic [7:0] pattern;
  logic [3:0] line;
  logic [3:0] crow;
  logic       half;
  logic       disp_en;  // cleared by reset, re-armed at the top of the window

  logic       v_act;
  logic       fetch_act;
  logic       win_act;
  logic [8:0] fetch_rel;
  logic [3:0] phase;
  logic [4:0] col;
  logic [2:0] pix_idx;

  assign v_act     = (pix_y >= Y_WIN_LO) && (pix_y < Y_WIN_HI);
  assign fetch_act = v_act && (pix_x >= X_FETCH_LO) && (pix_x < X_FETCH_HI);
  assign win_act   = v_act && (pix_x >= X_WIN_LO) && (pix_x < X_WIN_HI);

  assign fetch_rel = 9'(pix_x - X_FETCH_LO);
  assign phase     = fetch_rel[3:0];
  assign col       = fetch_rel[8:4];
  assign pix_idx   = 3'((pix_x - X_WIN_LO) >> 1);

  assign cg_addr   = {code_r[GLYPH_MSB:GLYPH_LSB], line};

  vga_text_pattern u_pattern (
    .sg4     (code_r[CODE_SG4_BIT]),
    .inv     (code_r[CODE_INV_BIT]),
    .quad    (code_r[3:0]),
    .line    (line),
    .cg_data (cg_data),
    .pattern (pattern)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the value from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr <= '0;
      code_r    <= '0;
      next_pat  <= '0;
      cur_pat   <= '0;
      line      <= '0;
      crow      <= '0;
      half      <= 1'b0;
      disp_en   <= 1'b0;
      pixel     <= 1'b0;
      pixel_en  <= 1'b0;
    end else begin
      // Vertical position advances once per line, at the left edge
      if (pix_x == '0) begin
        if (pix_y == Y_WIN_LO) begin
          half    <= 1'b0;
          line    <= '0;
          crow    <= '0;
          disp_en <= 1'b1;
        end else if ((pix_y > Y_WIN_LO) && (pix_y < Y_WIN_HI)) begin
          half <= ~half;
          if (half) begin
            if (line == 4'(LINES_PER_ROW - 1)) begin
              line <= '0;
              crow <= crow + 4'd1;
            end else begin
              line <= line + 4'd1;
            end
          end
        end
      end

      if (fetch_act) begin
        case (phase)
          PH_ADDR:  vram_addr <= {crow, col};
          PH_CODE:  code_r    <= vram_data;
          PH_PAT:   next_pat  <= pattern;
          PH_SHIFT: cur_pat   <= next_pat;
          default:  ;
        endcase
      end

      if (win_act && disp_en) begin
        pixel    <= cur_pat[3'd7 - pix_idx];
        pixel_en <= 1'b1;
      end else begin
        pixel    <= 1'b0;
        pixel_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Bench for vga_text_fetch: directed frames with a vector table, then random
// video RAM contents checked every cycle against a coordinate-based model.
module tb_vga_text_fetch;
  import vga_text_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic [8:0] vram_addr;
  logic [7:0] vram_data;
  logic [9:0] cg_addr;
  logic [7:0] cg_data;
  logic       pixel;
  logic       pixel_en;

  logic [7:0] vram [512];
  logic [7:0] rom  [1024];

  always #5 clk = ~clk;

  always @(posedge clk) vram_data <= vram[vram_addr];
  assign cg_data = rom[cg_addr];

  vga_text_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .cg_addr   (cg_addr),
    .cg_data   (cg_data),
    .pixel     (pixel),
    .pixel_en  (pixel_en)
  );

  typedef enum {S_PIX, S_EN, S_VADDR, S_CG} sig_e;
  typedef struct {
    int   frame;
    int   y;
    int   x;
    sig_e sig;
    int   want;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int passed = 0;

  // Reference state: display armed, and whether the expected address is known
  bit disp_on   = 1'b0;
  bit known     = 1'b0;
  int exp_vaddr = 0;
  int cur_frame = -1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d at x=%0d y=%0d frame=%0d",
                  name, actual, expected, pix_x, pix_y, cur_frame);
  endtask

  function automatic logic [7:0] model_pat(input logic [7:0] code, input int ln);
    logic [9:0] a;
    logic       l;
    logic       r;
    a = {code[5:0], 4'(ln)};
    if (code[7]) begin
      l = (ln < 6) ? code[3] : code[1];
      r = (ln < 6) ? code[2] : code[0];
      return {{4{l}}, {4{r}}};
    end
    if (code[6]) return ~rom[a];
    return rom[a];
  endfunction

  // One pixel clock at (x,y); outputs are compared #1 after the edge.
  task automatic run_cycle(input int x, input int y, input bit rst);
    bit         in_win;
    logic       exp_pix;
    logic [7:0] pat;
    pix_x = 10'(x);
    pix_y = 10'(y);
    reset = rst;
    // cg_addr depends only on registers, so it is checked before the edge
    foreach (tbl[i])
      if (tbl[i].frame == cur_frame && tbl[i].y == y && tbl[i].x == x && tbl[i].sig == S_CG)
        check("vec_cg_addr", int'(cg_addr), tbl[i].want);
    @(posedge clk);
    #1;
    in_win  = disp_on && !rst && x >= 64 && x < 576 && y >= 48 && y < 432;
    exp_pix = 1'b0;
    if (in_win) begin
      pat     = model_pat(vram[((y - 48) / 24) * 32 + (x - 64) / 16], ((y - 48) / 2) % 12);
      exp_pix = pat[7 - ((x - 64) % 16) / 2];
    end
    check("pixel", int'(pixel), int'(exp_pix));
    check("pixel_en", int'(pixel_en), int'(in_win));
    if (rst) begin
      disp_on   = 1'b0;
      known     = 1'b0;
      exp_vaddr = 0;
    end else begin
      if (x == 0 && y == 48) disp_on = 1'b1;
      if (y >= 48 && y < 432 && x >= 48 && x < 560 && (x - 48) % 16 == 0) begin
        exp_vaddr = ((y - 48) / 24) * 32 + (x - 48) / 16;
        if (y == 48) known = 1'b1;
      end
    end
    if (known || rst) check("vram_addr", int'(vram_addr), exp_vaddr);
    foreach (tbl[i])
      if (tbl[i].frame == cur_frame && tbl[i].y == y && tbl[i].x == x) begin
        case (tbl[i].sig)
          S_PIX:   check("vec_pixel", int'(pixel), tbl[i].want);
          S_EN:    check("vec_pixel_en", int'(pixel_en), tbl[i].want);
          S_VADDR: check("vec_vram_addr", int'(vram_addr), tbl[i].want);
          default: ;
        endcase
      end
  endtask

  function automatic bit needs_full(input int fid, input int y);
    foreach (tbl[i]) if (tbl[i].frame == fid && tbl[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  // Lines 46..433; untested lines are shortened to their x=0 cycle only.
  task automatic run_frame(input int fid, input int div, input int rst_y, input int rst_x);
    cur_frame = fid;
    for (int y = 46; y <= 433; y++) begin
      bit full;
      full = needs_full(fid, y) || (y == rst_y) ||
             (div != 0 && $urandom_range(div - 1) == 0);
      if (full) begin
        for (int x = 0; x < 640; x++) run_cycle(x, y, (y == rst_y) && (x == rst_x));
      end else begin
        run_cycle(0, y, 1'b0);
      end
    end
  endtask

  task automatic fill_vram(input bit rnd);
    for (int i = 0; i < 512; i++) vram[i] = rnd ? 8'($urandom) : 8'h20;
  endtask

  initial begin
    // Frame 0: all spaces -- window edges and address sequencing
    tbl.push_back('{0,  47, 300, S_EN,    0});
    tbl.push_back('{0,  48,  63, S_EN,    0});
    tbl.push_back('{0,  48,  64, S_EN,    1});
    tbl.push_back('{0,  48,  64, S_PIX,   0});
    tbl.push_back('{0,  48, 575, S_EN,    1});
    tbl.push_back('{0,  48, 576, S_EN,    0});
    tbl.push_back('{0, 200, 300, S_PIX,   0});
    tbl.push_back('{0, 168,  48, S_VADDR, 160});
    tbl.push_back('{0, 168,  64, S_VADDR, 161});
    tbl.push_back('{0, 168, 544, S_VADDR, 191});
    tbl.push_back('{0, 168, 600, S_VADDR, 191});
    tbl.push_back('{0, 431,  48, S_VADDR, 480});
    tbl.push_back('{0, 431,  51, S_CG,    523});
    tbl.push_back('{0, 431, 575, S_EN,    1});
    tbl.push_back('{0, 432, 300, S_EN,    0});
    // Frame 1: 'A' at cell 0, SG4 TL+BR at row 1 col 1
    tbl.push_back('{1,  56,  51, S_CG,    'h014});
    tbl.push_back('{1,  56,  64, S_PIX,   0});
    tbl.push_back('{1,  56,  69, S_PIX,   0});
    tbl.push_back('{1,  56,  70, S_PIX,   1});
    tbl.push_back('{1,  56,  71, S_PIX,   1});
    tbl.push_back('{1,  56,  72, S_PIX,   0});
    tbl.push_back('{1,  56,  73, S_PIX,   0});
    tbl.push_back('{1,  56,  74, S_PIX,   1});
    tbl.push_back('{1,  56,  75, S_PIX,   1});
    tbl.push_back('{1,  56,  76, S_PIX,   0});
    tbl.push_back('{1,  56,  79, S_PIX,   0});
    tbl.push_back('{1,  72,  79, S_PIX,   0});
    tbl.push_back('{1,  72,  80, S_PIX,   1});
    tbl.push_back('{1,  72,  87, S_PIX,   1});
    tbl.push_back('{1,  72,  88, S_PIX,   0});
    tbl.push_back('{1,  83,  87, S_PIX,   1});
    tbl.push_back('{1,  83,  88, S_PIX,   0});
    tbl.push_back('{1,  84,  87, S_PIX,   0});
    tbl.push_back('{1,  84,  88, S_PIX,   1});
    tbl.push_back('{1,  84,  95, S_PIX,   1});
    tbl.push_back('{1,  84,  96, S_PIX,   0});
    tbl.push_back('{1,  95,  80, S_PIX,   0});
    tbl.push_back('{1,  95,  95, S_PIX,   1});
    // Frame 2: inverse 'A' on its blank top line
    tbl.push_back('{2,  48,  64, S_PIX,   1});
    tbl.push_back('{2,  48,  71, S_PIX,   1});
    tbl.push_back('{2,  48,  79, S_PIX,   1});
    tbl.push_back('{2,  48,  80, S_PIX,   0});
    // Frame 3: reset at x=300 mid-frame blanks the rest of the frame
    tbl.push_back('{3, 100, 300, S_PIX,   0});
    tbl.push_back('{3, 100, 300, S_EN,    0});
    tbl.push_back('{3, 100, 301, S_EN,    0});
    tbl.push_back('{3, 150, 300, S_EN,    0});
    tbl.push_back('{3, 431, 200, S_EN,    0});
    // Frame 4: display resumes at the next top line
    tbl.push_back('{4,  48,  64, S_EN,    1});
    tbl.push_back('{4,  48, 300, S_EN,    1});

    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int l = 0; l < 16; l++) rom[512 + l] = 8'h00;  // space glyph
    rom[16] = 8'h00;
    rom[20] = 8'h14;
    fill_vram(1'b0);

    run_cycle(0, 0, 1'b1);
    run_cycle(7, 0, 1'b1);
    check("reset_vram_addr", int'(vram_addr), 0);
    check("reset_pixel", int'(pixel), 0);
    check("reset_pixel_en", int'(pixel_en), 0);

    run_frame(0, 32, -1, -1);

    vram[0]  = 8'h01;
    vram[33] = 8'h89;
    run_frame(1, 0, -1, -1);

    fill_vram(1'b0);
    vram[0] = 8'h41;
    run_frame(2, 0, -1, -1);

    fill_vram(1'b1);
    run_frame(3, 24, 100, 300);
    fill_vram(1'b1);
    run_frame(4, 24, -1, -1);
    fill_vram(1'b1);
    run_frame(5, 24, -1, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_fetch.md
Name: vga_text_fetch

Overview:
- Text-mode video fetch and serialiser for the VGA path. It sits directly upstream of the character generator ROM and downstream of the VGA timing generator.
- Display is Atom/6847 style: 32 columns x 16 rows of 8x12 cells, each source pixel doubled in x and y, giving a 512x384 window inside 640x480.
- Per cell it reads the character code from video RAM, drives the ROM address ({code[5:0], line[3:0]}), and applies inverse or semigraphics-4 to the returned row byte. It then shifts the result out as one mono pixel per clock.

Parameters:
X_START, 64, first active pixel column of the text window (must be >= 20).
Y_START, 48, first active line of the text window.

Ports:
clk  in  1  pixel clock (25.175 MHz).
reset  in  1  synchronous, active-high reset.
pix_x  in  10  current pixel column from timing generator.
pix_y  in  10  current line from timing generator.
vram_addr  out  9  video RAM offset {crow[3:0], col[4:0]}, registered.
vram_data  in  8  character code; synchronous RAM, valid one cycle after vram_addr changes.
cg_addr  out  10  character ROM address {code_r[5:0], line[3:0]}, combinational from registers.
cg_data  in  8  ROM row byte, combinational, same cycle; bit7 is the leftmost pixel.
pixel  out  1  mono pixel, registered.
pixel_en  out  1  high when pixel lies inside the text window, registered.

Behaviour:
- Reset: vram_addr=0, pixel=0, pixel_en=0. Also cleared: code_r, next_pat, cur_pat, line, half, crow, and the column counter. Reset asserted mid-frame has effect on the next edge; normal output resumes at the next pix_y==Y_START.
- Vertical counters are updated on the cycle where pix_x==0:
  - pix_y==Y_START: half=0, line=0, crow=0.
  - Y_START < pix_y < Y_START+384: half toggles. On half 1->0, line increments; at line 11->0, crow increments.
  - Otherwise the counters hold.
- Vertical window active: Y_START <= pix_y < Y_START+384.
- Fetch window: X_START-16 <= pix_x < X_START+496, vertical window active.
  - phase = (pix_x-(X_START-16))[3:0].
  - Cell n (0..31) is fetched during x = X_START+16(n-1) .. +15.
- Fetch phases:
  - phase 0 edge: vram_addr <= {crow, n}.
  - phase 2 edge: code_r <= vram_data.
  - phase 3: cg_addr is valid and cg_data is sampled. At the edge, next_pat is loaded by the transform below.
  - phase 15 edge: cur_pat <= next_pat.
- Transform:
  - code_r[7]=1 → semigraphics-4. Quadrant bit = line<6 ? (code_r[3] for the left nibble, code_r[2] for the right) : (code_r[1] for the left, code_r[0] for the right). Each nibble is 4'hF if its bit is set, else 4'h0. Bits 6:4 are ignored (mono).
  - code_r[7]=0, code_r[6]=1 → ~cg_data (the whole cell inverts, blank rows become 8'hFF).
  - Otherwise cg_data.
- Output, registered with a latency of exactly 1 cycle from pix_x/pix_y:
  - Inside window (X_START <= pix_x < X_START+512, vertical window active): pixel <= cur_pat[7-(pix_x-X_START)[3:1]], pixel_en <= 1.
  - Outside window: pixel <= 0, pixel_en <= 0.
- cur_pat is not updated outside the fetch window.
- vram_addr holds its last value outside the fetch window.
- pix_x wrap: no special handling. The window tests are magnitude compares; out-of-range pix_x/pix_y simply give a border.

Decomposition:
- Shared package: X/Y window constants, COLS=32, ROWS=16, LINES_PER_ROW=12, and a code-field localparam set (SG4 bit 7, INV bit 6, glyph bits 5:0).
- Natural sub-module: vga_text_pattern, the combinational transform (code_r, line, cg_data) -> 8-bit pattern. Everything else stays in one module.

Test Plan:
- VRAM all 8'h20 (space), full frame → pixel=0 everywhere, pixel_en=1 exactly for x in 64..575, y in 48..431, with 1-cycle lag.
- VRAM[0]=8'h01 ('A'), y=Y_START+8 (line 4) → cg_addr=10'h014 at phase 3 of cell 0. pixel=1 one cycle after x=70,71,74,75; 0 elsewhere in x 64..79.
- VRAM[0]=8'h41 (inverse 'A'), y=Y_START (line 0) → pixel=1 for all 16 pixels at x 64..79.
- VRAM[33]=8'h89 (SG4, quadrants TL+BR), row 1 col 1 → for y 72..83 pixel=1 only at x 80..87; for y 84..95 pixel=1 only at x 88..95.
- Address sequencing, y=Y_START+24*5 → vram_addr steps 160,161..191 at x=48,64..544. At y=Y_START+383, crow=15 and line=11; at y=Y_START+384, pixel_en=0.
- Assert reset for 1 cycle at x=300 mid-frame → pixel and pixel_en are 0 the next cycle and stay 0 for the rest of the frame. Correct display resumes at the next y=48.
